// File: rtl/rf_wr_arbiter_if.sv
// Bundle of the writeback, auxiliary-producer, hazard-query and GRF write-port
// signals around rf_wr_arbiter.
interface rf_wr_arbiter_if;
  logic        wb_en;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic [31:0] wb_pc;
  logic        wb_stall;

  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_a3;
  logic [31:0] aux_wd;
  logic [31:0] aux_pc;

  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        hit1;
  logic        hit2;

  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_pc;

  modport master (
    output wb_en, wb_a3, wb_wd, wb_pc,
    output aux_valid, aux_a3, aux_wd, aux_pc,
    output q_a1, q_a2,
    input  wb_stall, aux_ready, hit1, hit2,
    input  rf_we, rf_a3, rf_wd, rf_pc
  );

  modport slave (
    input  wb_en, wb_a3, wb_wd, wb_pc,
    input  aux_valid, aux_a3, aux_wd, aux_pc,
    input  q_a1, q_a2,
    output wb_stall, aux_ready, hit1, hit2,
    output rf_we, rf_a3, rf_wd, rf_pc
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the GRF write port between W-stage writeback and a buffered auxiliary
// producer; writeback wins unless the FIFO head has starved for MAX_WAIT cycles.
module rf_wr_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic           clk,
  input  logic           reset,
  rf_wr_arbiter_if.slave bus
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [4:0]       fifo_a3 [DEPTH];
  logic [31:0]      fifo_wd [DEPTH];
  logic [31:0]      fifo_pc [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [CW-1:0]    cnt;

  logic        non_empty;
  logic        full;
  logic        push;
  logic        push_store;
  logic        wb_req;
  logic        force_slot;
  logic        grant_wb;
  logic        grant_fifo;
  logic        head_vld;
  logic        hit1_c;
  logic        hit2_c;

  logic        rf_we_q;
  logic [4:0]  rf_a3_q;
  logic [31:0] rf_wd_q;
  logic [31:0] rf_pc_q;

  assign non_empty  = (occ != '0);
  assign full       = (occ == OW'(DEPTH));
  assign push       = bus.aux_valid && !full;
  // Writes to $0 complete the handshake but never take a slot.
  assign push_store = push && (bus.aux_a3 != 5'd0);
  assign wb_req     = bus.wb_en && (bus.wb_a3 != 5'd0);
  assign force_slot = non_empty && (cnt == CW'(MAX_WAIT));
  assign grant_fifo = non_empty && (force_slot || !wb_req);
  assign grant_wb   = wb_req && !force_slot;
  assign head_vld   = fifo_vld[rd_ptr];

  assign bus.aux_ready = !full;
  assign bus.wb_stall  = force_slot && wb_req;

  always_comb begin
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_a3[i] == bus.q_a1)) hit1_c = 1'b1;
      if (fifo_vld[i] && (fifo_a3[i] == bus.q_a2)) hit2_c = 1'b1;
    end
    if (push_store && (bus.aux_a3 == bus.q_a1)) hit1_c = 1'b1;
    if (push_store && (bus.aux_a3 == bus.q_a2)) hit2_c = 1'b1;
    if (bus.q_a1 == 5'd0) hit1_c = 1'b0;
    if (bus.q_a2 == 5'd0) hit2_c = 1'b0;
  end

  assign bus.hit1 = hit1_c;
  assign bus.hit2 = hit2_c;

  // Payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push_store) begin
      fifo_a3[wr_ptr] <= bus.aux_a3;
      fifo_wd[wr_ptr] <= bus.aux_wd;
      fifo_pc[wr_ptr] <= bus.aux_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      cnt      <= '0;
    end else begin
      // A granted writeback makes older buffered values to the same register stale.
      if (grant_wb) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_a3[i] == bus.wb_a3) fifo_vld[i] <= 1'b0;
        end
      end
      if (grant_fifo) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      // Placed after the squash so a same-cycle push to that register stays valid.
      if (push_store) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      case ({push_store, grant_fifo})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (!non_empty || grant_fifo)
        cnt <= '0;
      else if (cnt != CW'(MAX_WAIT))
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
      rf_pc_q <= '0;
    end else if (grant_wb) begin
      rf_we_q <= 1'b1;
      rf_a3_q <= bus.wb_a3;
      rf_wd_q <= bus.wb_wd;
      rf_pc_q <= bus.wb_pc;
    end else if (grant_fifo && head_vld) begin
      rf_we_q <= 1'b1;
      rf_a3_q <= fifo_a3[rd_ptr];
      rf_wd_q <= fifo_wd[rd_ptr];
      rf_pc_q <= fifo_pc[rd_ptr];
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_a3 = rf_a3_q;
  assign bus.rf_wd = rf_wd_q;
  assign bus.rf_pc = rf_pc_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed scenarios for rf_wr_arbiter; every GRF write is matched in order
// against a queue of expected writes filled as stimulus is driven.
module tb_rf_wr_arbiter;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  wr_t  exp_q [$];

  rf_wr_arbiter_if bus ();

  rf_wr_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    wr_t e;
    e.a3 = a3;
    e.wd = wd;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.wb_en     = 1'b0;
    bus.wb_a3     = 5'd0;
    bus.wb_wd     = 32'd0;
    bus.wb_pc     = 32'd0;
    bus.aux_valid = 1'b0;
    bus.aux_a3    = 5'd0;
    bus.aux_wd    = 32'd0;
    bus.aux_pc    = 32'd0;
    bus.q_a1      = 5'd0;
    bus.q_a2      = 5'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.wb_en = 1'b1;
    bus.wb_a3 = a3;
    bus.wb_wd = wd;
    bus.wb_pc = pc;
  endtask

  task automatic drive_aux(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.aux_valid = 1'b1;
    bus.aux_a3    = a3;
    bus.aux_wd    = wd;
    bus.aux_pc    = pc;
  endtask

  // Write monitor: each rf_we must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 64'(bus.rf_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_a3", 64'(bus.rf_a3), 64'(e.a3));
        chk("wr_wd", 64'(bus.rf_wd), 64'(e.wd));
        chk("wr_pc", 64'(bus.rf_pc), 64'(e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle();
    repeat (2) cyc();
    chk("rst_we",    64'(bus.rf_we),     64'd0);
    chk("rst_a3",    64'(bus.rf_a3),     64'd0);
    chk("rst_wd",    64'(bus.rf_wd),     64'd0);
    chk("rst_pc",    64'(bus.rf_pc),     64'd0);
    chk("rst_ready", 64'(bus.aux_ready), 64'd1);
    chk("rst_stall", 64'(bus.wb_stall),  64'd0);
    reset = 1'b1;
    cyc();

    // Plain writeback, one-cycle latency
    drive_wb(5'd5, 32'h1234, 32'h100);
    expect_wr(5'd5, 32'h1234, 32'h100);
    #1;
    chk("basic_stall", 64'(bus.wb_stall), 64'd0);
    cyc();
    idle();
    chk("basic_we", 64'(bus.rf_we), 64'd1);
    chk("basic_a3", 64'(bus.rf_a3), 64'd5);
    chk("basic_wd", 64'(bus.rf_wd), 64'h1234);
    cyc();
    chk("basic_we_off", 64'(bus.rf_we), 64'd0);
    chk("basic_a3_hold", 64'(bus.rf_a3), 64'd5);

    // Starvation: head denied 3 cycles, then forced
    drive_aux(5'd7, 32'h77, 32'h200);
    bus.q_a1 = 5'd7;
    #1;
    chk("push_hit1", 64'(bus.hit1), 64'd1);
    cyc();
    bus.aux_valid = 1'b0;
    bus.q_a2      = 5'd7;
    for (int i = 0; i < 3; i++) begin
      drive_wb(5'd3, 32'h300 + 32'(i), 32'h400 + 32'(4 * i));
      expect_wr(5'd3, 32'h300 + 32'(i), 32'h400 + 32'(4 * i));
      #1;
      chk("starve_stall", 64'(bus.wb_stall), 64'd0);
      chk("starve_hit2", 64'(bus.hit2), 64'd1);
      cyc();
    end
    drive_wb(5'd3, 32'h303, 32'h40c);
    expect_wr(5'd7, 32'h77, 32'h200);
    #1;
    chk("force_stall", 64'(bus.wb_stall), 64'd1);
    cyc();
    chk("force_a3", 64'(bus.rf_a3), 64'd7);
    chk("popped_hit1", 64'(bus.hit1), 64'd0);
    expect_wr(5'd3, 32'h303, 32'h40c);
    #1;
    chk("resume_stall", 64'(bus.wb_stall), 64'd0);
    cyc();
    chk("resume_a3", 64'(bus.rf_a3), 64'd3);
    idle();
    cyc();

    // Squash: younger writeback to $9 kills the buffered value
    drive_aux(5'd9, 32'hAAAA, 32'h500);
    bus.q_a2 = 5'd9;
    #1;
    chk("sq_push_hit2", 64'(bus.hit2), 64'd1);
    cyc();
    bus.aux_valid = 1'b0;
    bus.q_a1      = 5'd9;
    #1;
    chk("sq_pend_hit1", 64'(bus.hit1), 64'd1);
    drive_wb(5'd9, 32'hBBBB, 32'h600);
    expect_wr(5'd9, 32'hBBBB, 32'h600);
    #1;
    chk("sq_stall", 64'(bus.wb_stall), 64'd0);
    cyc();
    idle();
    bus.q_a1 = 5'd9;
    #1;
    chk("sq_hit1_gone", 64'(bus.hit1), 64'd0);
    cyc();
    chk("sq_pop_we", 64'(bus.rf_we), 64'd0);
    idle();
    cyc();

    // Fill to DEPTH under continuous writeback, then drain with wrap
    for (int c = 0; c < 6; c++) begin
      logic [4:0] a3;
      a3 = 5'd10 + 5'((c < 4) ? c : 4);
      drive_wb(5'd20, 32'h5000 + 32'(c), 32'h700 + 32'(4 * c));
      drive_aux(a3, 32'hE000 + 32'(a3), 32'h800 + 32'(a3));
      if (c == 4) expect_wr(5'd10, 32'hE00A, 32'h80A);
      else        expect_wr(5'd20, 32'h5000 + 32'(c), 32'h700 + 32'(4 * c));
      #1;
      if (c == 3) chk("fill_ready_c3", 64'(bus.aux_ready), 64'd1);
      if (c == 4) begin
        chk("full_ready", 64'(bus.aux_ready), 64'd0);
        chk("full_stall", 64'(bus.wb_stall), 64'd1);
      end
      if (c == 5) begin
        chk("refill_ready", 64'(bus.aux_ready), 64'd1);
        chk("refill_stall", 64'(bus.wb_stall), 64'd0);
      end
      cyc();
    end
    idle();
    for (int k = 1; k <= 4; k++)
      expect_wr(5'd10 + 5'(k), 32'hE00A + 32'(k), 32'h80A + 32'(k));
    repeat (6) cyc();
    chk("full_drained", 64'(exp_q.size()), 64'd0);

    // Register 0 requests
    drive_aux(5'd0, 32'hDEAD, 32'h900);
    drive_wb(5'd0, 32'hBEEF, 32'h904);
    #1;
    chk("z_ready", 64'(bus.aux_ready), 64'd1);
    chk("z_stall", 64'(bus.wb_stall),  64'd0);
    chk("z_hit1",  64'(bus.hit1),      64'd0);
    chk("z_hit2",  64'(bus.hit2),      64'd0);
    cyc();
    idle();
    cyc();
    chk("z_we", 64'(bus.rf_we), 64'd0);
    cyc();

    // Mid-operation reset with two buffered entries
    drive_wb(5'd21, 32'h2100, 32'hA00);
    drive_aux(5'd11, 32'h1100, 32'hB00);
    expect_wr(5'd21, 32'h2100, 32'hA00);
    cyc();
    drive_wb(5'd22, 32'h2200, 32'hA04);
    drive_aux(5'd12, 32'h1200, 32'hB04);
    expect_wr(5'd22, 32'h2200, 32'hA04);
    cyc();
    idle();
    bus.q_a1 = 5'd11;
    bus.q_a2 = 5'd12;
    #1;
    chk("pre_rst_hit1", 64'(bus.hit1), 64'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst2_we",    64'(bus.rf_we),     64'd0);
    chk("rst2_a3",    64'(bus.rf_a3),     64'd0);
    chk("rst2_ready", 64'(bus.aux_ready), 64'd1);
    chk("rst2_hit1",  64'(bus.hit1),      64'd0);
    chk("rst2_hit2",  64'(bus.hit2),      64'd0);
    repeat (2) cyc();
    reset = 1'b1;
    repeat (4) cyc();
    chk("post_rst_we",   64'(bus.rf_we), 64'd0);
    chk("post_rst_hit1", 64'(bus.hit1),  64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
